// File: rtl/tetris_action_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------------------------+
// | Module   : tetris_action_sched                                                               |
// | Purpose  : debounces the game keys, generates gravity/auto-repeat requests and issues at     |
// |            most one one-hot action pulse per video frame, aligned to the vs rising edge.     |
// | Revision : 1.0 - initial release                                                             |
// +----------------------------------------------------------------------------------------------+
module tetris_action_sched #(
    parameter logic [15:0] DB_CYC      = 16'd50000,
    parameter logic [7:0]  GRAV_FRAMES = 8'd30,
    parameter logic [7:0]  FAST_FRAMES = 8'd2,
    parameter logic [7:0]  RPT_DELAY   = 8'd12,
    parameter logic [7:0]  RPT_RATE    = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       rotate,
    input  logic       fall,
    input  logic       vs,
    input  logic       run,
    input  logic       array_busy,
    output logic [3:0] action,
    output logic [3:0] led
);

    localparam int c_left  = 3;
    localparam int c_right = 2;
    localparam int c_rot   = 1;
    localparam int c_down  = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [3:0]  w_keys_d;
    logic [3:0]  r_sync1_q;
    logic [3:0]  r_sync2_q;
    logic [3:0]  r_db_q;
    logic [3:0]  w_db_d;
    logic [15:0] r_dbc_q [4];
    logic [15:0] w_dbc_d [4];
    logic [3:0]  r_led_q;
    logic [3:0]  w_led_d;
    logic [3:0]  r_pend_q;
    logic [3:0]  w_pend_d;
    logic        r_vs_q;
    logic [7:0]  r_gc_q;
    logic [7:0]  w_gc_d;
    logic [7:0]  r_rcl_q;
    logic [7:0]  w_rcl_d;
    logic [7:0]  r_rcr_q;
    logic [7:0]  w_rcr_d;
    logic [1:0]  r_state_q;
    logic [1:0]  w_state_d;

    logic        w_ftk;
    logic        w_grav_set;
    logic        w_rpt_l;
    logic        w_rpt_r;
    logic [7:0]  w_grav_lim;
    logic [3:0]  w_rise;
    logic [3:0]  w_set;
    logic [3:0]  w_req;
    logic [3:0]  w_avail;

    // Returns {request, next count}. After RPT_DELAY frames the count is parked at RPT_DELAY
    // and re-fires every RPT_RATE frames, so it never runs away while a key is held.
    function automatic logic [8:0] rpt_step(input logic held, input logic tick,
                                            input logic [7:0] cnt);
        logic [7:0] inc;
        inc = cnt + 8'd1;
        if (!held) return 9'd0;
        if (!tick) return {1'b0, cnt};
        if (inc == RPT_DELAY) return {1'b1, inc};
        if (inc == RPT_DELAY + RPT_RATE) return {1'b1, RPT_DELAY};
        return {1'b0, inc};
    endfunction

    assign w_keys_d = {left, right, rotate, fall};
    assign w_ftk    = vs & ~r_vs_q;
    assign led      = r_led_q;

    always_comb begin
        w_db_d = r_db_q;
        for (int i = 0; i < 4; i++) begin
            w_dbc_d[i] = '0;
            if (r_sync2_q[i] != r_db_q[i]) begin
                if (r_dbc_q[i] == DB_CYC - 16'd1) w_db_d[i] = r_sync2_q[i];
                else                             w_dbc_d[i] = r_dbc_q[i] + 16'd1;
            end
        end
        w_rise  = w_db_d & ~r_db_q;
        w_led_d = r_led_q ^ w_rise;
    end

    always_comb begin
        {w_rpt_l, w_rcl_d} = rpt_step(r_db_q[c_left],  w_ftk, r_rcl_q);
        {w_rpt_r, w_rcr_d} = rpt_step(r_db_q[c_right], w_ftk, r_rcr_q);

        w_grav_lim = r_db_q[c_down] ? FAST_FRAMES : GRAV_FRAMES;
        w_grav_set = 1'b0;
        w_gc_d     = r_gc_q;
        if (w_rise[c_down]) begin
            w_gc_d = '0;
        end else if (w_ftk && run) begin
            if (r_gc_q >= w_grav_lim - 8'd1) begin
                w_gc_d     = '0;
                w_grav_set = 1'b1;
            end else begin
                w_gc_d = r_gc_q + 8'd1;
            end
        end
    end

    // A request raised in the same cycle its bit is issued survives; opposing moves cancel.
    always_comb begin
        w_set = w_rise | {w_rpt_l, w_rpt_r, 1'b0, w_grav_set};
        w_req = r_pend_q | w_set;
        w_avail = w_req;
        if (w_req[c_left] && w_req[c_right]) begin
            w_avail[c_left]  = 1'b0;
            w_avail[c_right] = 1'b0;
        end
        w_pend_d = (r_pend_q & ~action) | w_set;
        if (w_pend_d[c_left] && w_pend_d[c_right]) begin
            w_pend_d[c_left]  = 1'b0;
            w_pend_d[c_right] = 1'b0;
        end
        if (!run) w_pend_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1_q <= '0;
            r_sync2_q <= '0;
            r_db_q    <= '0;
            r_led_q   <= '0;
            r_pend_q  <= '0;
            r_vs_q    <= 1'b0;
            r_gc_q    <= '0;
            r_rcl_q   <= '0;
            r_rcr_q   <= '0;
            for (int i = 0; i < 4; i++) r_dbc_q[i] <= '0;
        end else begin
            r_sync1_q <= w_keys_d;
            r_sync2_q <= r_sync1_q;
            r_db_q    <= w_db_d;
            r_led_q   <= w_led_d;
            r_pend_q  <= w_pend_d;
            r_vs_q    <= vs;
            r_gc_q    <= w_gc_d;
            r_rcl_q   <= w_rcl_d;
            r_rcr_q   <= w_rcr_d;
            for (int i = 0; i < 4; i++) r_dbc_q[i] <= w_dbc_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state_q <= S_IDLE;
        else     r_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE:  if (w_ftk && run && !array_busy && (|w_avail)) w_state_d = S_ISSUE;
            S_ISSUE: w_state_d = S_WAIT;
            S_WAIT:  if (!array_busy) w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        action = '0;
        if (r_state_q == S_ISSUE) begin
            if      (r_pend_q[c_rot])   action[c_rot]   = 1'b1;
            else if (r_pend_q[c_left])  action[c_left]  = 1'b1;
            else if (r_pend_q[c_right]) action[c_right] = 1'b1;
            else if (r_pend_q[c_down])  action[c_down]  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tetris_action_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------------------------+
// | Module   : tb_tetris_action_sched                                                            |
// | Purpose  : directed, table-driven bench for tetris_action_sched (one table row per frame).   |
// | Revision : 1.0 - initial release                                                             |
// +----------------------------------------------------------------------------------------------+
module tb_tetris_action_sched;

    logic       clk;
    logic       rst;
    logic       left;
    logic       right;
    logic       rotate;
    logic       fall;
    logic       vs;
    logic       run;
    logic       array_busy;
    logic [3:0] action;
    logic [3:0] led;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       do_rst;
        logic [3:0] keys;
        logic       run;
        logic       busy;
        logic [3:0] exp_act;
        logic [3:0] exp_led;
    } vec_t;

    vec_t vecs[$];

    tetris_action_sched #(
        .DB_CYC      (16'd4),
        .GRAV_FRAMES (8'd3),
        .FAST_FRAMES (8'd1),
        .RPT_DELAY   (8'd2),
        .RPT_RATE    (8'd1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .left       (left),
        .right      (right),
        .rotate     (rotate),
        .fall       (fall),
        .vs         (vs),
        .run        (run),
        .array_busy (array_busy),
        .action     (action),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic set_keys(input logic [3:0] k);
        {left, right, rotate, fall} = k;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_keys(4'b0000);
        vs = 1'b0;
        array_busy = 1'b0;
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // 90 clk with vs low, then vs high; the tick's action is expected at offset 90.
    task automatic run_frame(output logic [3:0] act, output int n, output int off);
        act = '0;
        n   = 0;
        off = -1;
        for (int c = 0; c < 100; c++) begin
            vs = (c >= 90);
            @(posedge clk);
            #1;
            if (action != 4'b0000) begin
                act = action;
                n++;
                off = c;
            end
        end
    endtask

    task automatic addv(input logic r, input logic [3:0] k, input logic rn, input logic b,
                        input logic [3:0] ea, input logic [3:0] el);
        vec_t v;
        v.do_rst = r; v.keys = k; v.run = rn; v.busy = b; v.exp_act = ea; v.exp_led = el;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] act;
        int         n;
        int         off;
        int         led_changes;
        logic [3:0] led_prev;

        // Gravity every 3rd tick, then soft drop every tick.
        addv(1, 4'b0000, 1, 0, 4'b0000, 4'b0000);
        addv(0, 4'b0000, 1, 0, 4'b0000, 4'b0000);
        addv(0, 4'b0000, 1, 0, 4'b0001, 4'b0000);
        addv(0, 4'b0000, 1, 0, 4'b0000, 4'b0000);
        addv(0, 4'b0000, 1, 0, 4'b0000, 4'b0000);
        addv(0, 4'b0000, 1, 0, 4'b0001, 4'b0000);
        addv(0, 4'b0000, 1, 0, 4'b0000, 4'b0000);
        addv(0, 4'b0000, 1, 0, 4'b0000, 4'b0000);
        addv(0, 4'b0000, 1, 0, 4'b0001, 4'b0000);
        addv(0, 4'b0000, 1, 0, 4'b0000, 4'b0000);
        addv(0, 4'b0001, 1, 0, 4'b0001, 4'b0001);
        addv(0, 4'b0001, 1, 0, 4'b0001, 4'b0001);
        addv(0, 4'b0001, 1, 0, 4'b0001, 4'b0001);
        addv(0, 4'b0000, 1, 0, 4'b0000, 4'b0001);
        // Priority: rotate before right, then gravity.
        addv(1, 4'b0110, 1, 0, 4'b0010, 4'b0110);
        addv(0, 4'b0000, 1, 0, 4'b0100, 4'b0110);
        addv(0, 4'b0000, 1, 0, 4'b0001, 4'b0110);
        // Opposition, then left auto-repeat with a deferred gravity drop.
        addv(1, 4'b1100, 1, 0, 4'b0000, 4'b1100);
        addv(0, 4'b0000, 1, 0, 4'b0000, 4'b1100);
        addv(0, 4'b1000, 1, 0, 4'b1000, 4'b0100);
        addv(0, 4'b1000, 1, 0, 4'b1000, 4'b0100);
        addv(0, 4'b1000, 1, 0, 4'b1000, 4'b0100);
        addv(0, 4'b1000, 1, 0, 4'b1000, 4'b0100);
        addv(0, 4'b1000, 1, 0, 4'b1000, 4'b0100);
        addv(0, 4'b0000, 1, 0, 4'b0001, 4'b0100);
        addv(0, 4'b0000, 1, 0, 4'b0001, 4'b0100);
        // Busy holds pends; pause flushes pends and freezes gravity.
        addv(1, 4'b0010, 1, 1, 4'b0000, 4'b0010);
        addv(0, 4'b0000, 1, 1, 4'b0000, 4'b0010);
        addv(0, 4'b0000, 1, 1, 4'b0000, 4'b0010);
        addv(0, 4'b0000, 1, 0, 4'b0010, 4'b0010);
        addv(0, 4'b0000, 1, 0, 4'b0001, 4'b0010);
        addv(0, 4'b0010, 0, 0, 4'b0000, 4'b0000);
        addv(0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        addv(0, 4'b0000, 1, 0, 4'b0001, 4'b0000);

        rst = 1'b1;
        set_keys(4'b0000);
        vs = 1'b0;
        run = 1'b0;
        array_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_action", 32'(action), 32'h0);
        chk("reset_led", 32'(led), 32'h0);

        // Bouncing rotate: only the final steady level may register.
        do_reset();
        led_changes = 0;
        led_prev = led;
        for (int c = 0; c < 22; c++) begin
            rotate = (c >= 10) ? 1'b1 : ((c % 4) < 2);
            @(posedge clk);
            #1;
            if (led != led_prev) led_changes++;
            led_prev = led;
        end
        chk("bounce_led_toggles", 32'(led_changes), 32'd1);
        chk("bounce_led", 32'(led), 32'h2);
        run_frame(act, n, off);
        chk("bounce_action", 32'(act), 32'h2);
        chk("bounce_count", 32'(n), 32'd1);
        chk("bounce_latency", 32'(off), 32'd90);

        // Reset during the issue cycle.
        do_reset();
        rotate = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        vs = 1'b1;
        @(posedge clk);
        #1;
        chk("rstissue_action_before", 32'(action), 32'h2);
        rst = 1'b1;
        rotate = 1'b0;
        @(posedge clk);
        #1;
        chk("rstissue_action_after", 32'(action), 32'h0);
        chk("rstissue_led", 32'(led), 32'h0);
        rst = 1'b0;
        vs = 1'b0;
        run_frame(act, n, off);
        chk("rstissue_no_carry", 32'(n), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset();
            set_keys(vecs[i].keys);
            run = vecs[i].run;
            array_busy = vecs[i].busy;
            run_frame(act, n, off);
            chk($sformatf("row%0d_action", i), 32'(act), 32'(vecs[i].exp_act));
            chk($sformatf("row%0d_count", i), 32'(n), (vecs[i].exp_act != 4'b0000) ? 32'd1 : 32'd0);
            chk($sformatf("row%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
            if (vecs[i].exp_act != 4'b0000)
                chk($sformatf("row%0d_latency", i), 32'(off), 32'd90);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
